gemm_tile_sequencer: RTL and testbench



---
 rtl/npu_pkg.sv | 70 +++++++
 rtl/tile_counter.sv | 62 ++++++
 rtl/gemm_tile_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_gemm_tile_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// Shared NPU definitions: systolic-array opcodes, sequencer state encoding,
// the registered control bundle driven by the sequencer, and small helpers.
package npu_pkg;

    typedef enum logic [2:0] {
        OP_NOP     = 3'd0,
        OP_LOAD_W  = 3'd1,
        OP_MAC_CLR = 3'd2,
        OP_MAC_ACC = 3'd3,
        OP_DRAIN   = 3'd4
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_W  = 3'd1,
        S_COMPUTE = 3'd2,
        S_DRAIN   = 3'd3,
        S_WRITE   = 3'd4,
        S_DONE    = 3'd5
    } state_e;

    typedef struct packed {
        logic busy;
        logic done;
        logic a_buf_on;
        logic w_buf_on;
        logic mode;
        logic o_on;
        op_e  op;
    } ctl_t;

    function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
        return (num + den - 1) / den;
    endfunction

    // Control outputs that belong to a state; COMPUTE clears accumulators on the first K-tile.
    function automatic ctl_t ctl_for(input state_e s, input logic kt_zero);
        ctl_t c;
        c    = '0;
        c.op = OP_NOP;
        case (s)
            S_LOAD_W: begin
                c.busy     = 1'b1;
                c.w_buf_on = 1'b1;
                c.mode     = 1'b1;
                c.op       = OP_LOAD_W;
            end
            S_COMPUTE: begin
                c.busy     = 1'b1;
                c.a_buf_on = 1'b1;
                c.op       = kt_zero ? OP_MAC_CLR : OP_MAC_ACC;
            end
            S_DRAIN: begin
                c.busy = 1'b1;
                c.op   = OP_DRAIN;
            end
            S_WRITE: begin
                c.busy = 1'b1;
                c.o_on = 1'b1;
            end
            S_DONE: begin
                c.busy = 1'b1;
                c.done = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/tile_counter.sv
// Nested K-tile (kt, inner) / N-tile (nt, outer) counters with last-tile flags.
// Ports: i_clear loads tile totals and zeroes both counters; i_step_k advances kt;
// i_step_n zeroes kt and advances nt. o_*_nxt are the values after this cycle's edge.
module tile_counter #(
    parameter int unsigned DIM_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_clear,
    input  logic                 i_step_k,
    input  logic                 i_step_n,
    input  logic [DIM_WIDTH-1:0] i_kt_total,
    input  logic [DIM_WIDTH-1:0] i_nt_total,
    output logic [DIM_WIDTH-1:0] o_kt,
    output logic [DIM_WIDTH-1:0] o_kt_nxt,
    output logic [DIM_WIDTH-1:0] o_nt_nxt,
    output logic [DIM_WIDTH-1:0] o_kt_total,
    output logic                 o_k_last,
    output logic                 o_n_last
);

    logic [DIM_WIDTH-1:0] r_kt, r_nt, r_kt_total, r_nt_total;
    logic [DIM_WIDTH-1:0] w_kt_nxt, w_nt_nxt;

    always_comb begin
        w_kt_nxt = r_kt;
        w_nt_nxt = r_nt;
        if (i_clear) begin
            w_kt_nxt = '0;
            w_nt_nxt = '0;
        end else if (i_step_k) begin
            w_kt_nxt = r_kt + DIM_WIDTH'(1);
        end else if (i_step_n) begin
            w_kt_nxt = '0;
            w_nt_nxt = r_nt + DIM_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_kt       <= '0;
            r_nt       <= '0;
            r_kt_total <= '0;
            r_nt_total <= '0;
        end else begin
            r_kt <= w_kt_nxt;
            r_nt <= w_nt_nxt;
            if (i_clear) begin
                r_kt_total <= i_kt_total;
                r_nt_total <= i_nt_total;
            end
        end
    end

    assign o_kt       = r_kt;
    assign o_kt_nxt   = w_kt_nxt;
    assign o_nt_nxt   = w_nt_nxt;
    assign o_kt_total = r_kt_total;
    assign o_k_last   = (r_kt == r_kt_total - DIM_WIDTH'(1));
    assign o_n_last   = (r_nt == r_nt_total - DIM_WIDTH'(1));

endmodule

// File: rtl/gemm_tile_sequencer.sv
// GEMM tile sequencer: walks N-tiles (outer) and K-tiles (inner), driving weight
// preload, MAC, drain and output-write phases of a systolic array.
// Ports: start/abort control, cfg_* job description (latched on start), buffer
// enables/addresses/tile sizes, systolic opcode, relu_en, busy/done/err status.
module gemm_tile_sequencer
    import npu_pkg::*;
#(
    parameter int unsigned ARRAY_N    = 16,
    parameter int unsigned ARRAY_M    = 16,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DIM_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        abort,
    input  logic [DIM_WIDTH-1:0]        cfg_m,
    input  logic [DIM_WIDTH-1:0]        cfg_k,
    input  logic [DIM_WIDTH-1:0]        cfg_n,
    input  logic [ADDR_WIDTH-1:0]       cfg_a_base,
    input  logic [ADDR_WIDTH-1:0]       cfg_w_base,
    input  logic [ADDR_WIDTH-1:0]       cfg_o_base,
    input  logic                        cfg_relu,
    output logic                        a_buf_on,
    output logic [ADDR_WIDTH-1:0]       a_base_addr,
    output logic [$clog2(ARRAY_N):0]    a_num_rows,
    output logic                        w_buf_on,
    output logic                        mode,
    output logic [ADDR_WIDTH-1:0]       w_base_addr,
    output logic [$clog2(ARRAY_M):0]    w_num_cols,
    output logic [2:0]                  operation_signal,
    output logic                        o_ag_o_on,
    output logic [ADDR_WIDTH-1:0]       o_base_addr,
    output logic                        relu_en,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);

    localparam int unsigned PW = 3 * DIM_WIDTH;
    localparam int unsigned RW = $clog2(ARRAY_N) + 1;
    localparam int unsigned CW = $clog2(ARRAY_M) + 1;

    state_e                r_state;
    ctl_t                  r_ctl;
    logic                  r_err, r_relu;
    logic [DIM_WIDTH-1:0]  r_m, r_k, r_n, r_cnt;
    logic [ADDR_WIDTH-1:0] r_a_base, r_w_base, r_o_base;
    logic [ADDR_WIDTH-1:0] r_a_addr, r_w_addr, r_o_addr;
    logic [RW-1:0]         r_rows;
    logic [CW-1:0]         r_cols;

    logic                  w_idle, w_start, w_dims_zero, w_cnt_zero;
    logic                  w_step_k, w_step_n, w_load_addr, w_k_last, w_n_last;
    logic [DIM_WIDTH-1:0]  w_kt, w_kt_nxt, w_nt_nxt, w_kt_total_q;
    logic [DIM_WIDTH-1:0]  w_kt_total_in, w_nt_total_in, w_kt_total;
    logic [DIM_WIDTH-1:0]  w_sel_m, w_sel_k, w_sel_n;
    logic [ADDR_WIDTH-1:0] w_sel_a, w_sel_w, w_sel_o;
    logic [PW-1:0]         w_k_rem, w_n_rem;

    assign w_idle      = (r_state == S_IDLE);
    assign w_start     = w_idle && start && !abort;
    assign w_dims_zero = (cfg_m == '0) || (cfg_k == '0) || (cfg_n == '0);
    assign w_cnt_zero  = (r_cnt == '0);
    assign w_step_k    = (r_state == S_DRAIN) && w_cnt_zero && !w_k_last && !abort;
    assign w_step_n    = (r_state == S_WRITE) && w_cnt_zero && !w_n_last && !abort;
    assign w_load_addr = (w_start && !w_dims_zero) || w_step_k || w_step_n;

    assign w_kt_total_in = DIM_WIDTH'(ceil_div(32'(cfg_k), ARRAY_N));
    assign w_nt_total_in = DIM_WIDTH'(ceil_div(32'(cfg_n), ARRAY_M));

    tile_counter #(.DIM_WIDTH(DIM_WIDTH)) u_tile_counter (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (w_start),
        .i_step_k   (w_step_k),
        .i_step_n   (w_step_n),
        .i_kt_total (w_kt_total_in),
        .i_nt_total (w_nt_total_in),
        .o_kt       (w_kt),
        .o_kt_nxt   (w_kt_nxt),
        .o_nt_nxt   (w_nt_nxt),
        .o_kt_total (w_kt_total_q),
        .o_k_last   (w_k_last),
        .o_n_last   (w_n_last)
    );

    // On the start cycle the job parameters are not latched yet, so use the live inputs.
    assign w_sel_m    = w_idle ? cfg_m         : r_m;
    assign w_sel_k    = w_idle ? cfg_k         : r_k;
    assign w_sel_n    = w_idle ? cfg_n         : r_n;
    assign w_sel_a    = w_idle ? cfg_a_base    : r_a_base;
    assign w_sel_w    = w_idle ? cfg_w_base    : r_w_base;
    assign w_sel_o    = w_idle ? cfg_o_base    : r_o_base;
    assign w_kt_total = w_idle ? w_kt_total_in : w_kt_total_q;

    assign w_k_rem = PW'(w_sel_k) - PW'(w_kt_nxt) * PW'(ARRAY_N);
    assign w_n_rem = PW'(w_sel_n) - PW'(w_nt_nxt) * PW'(ARRAY_M);

    // Tile descriptors for the tile being entered; full-width math, wrap only at the output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_m      <= '0;
            r_k      <= '0;
            r_n      <= '0;
            r_a_base <= '0;
            r_w_base <= '0;
            r_o_base <= '0;
            r_relu   <= 1'b0;
            r_a_addr <= '0;
            r_w_addr <= '0;
            r_o_addr <= '0;
            r_rows   <= '0;
            r_cols   <= '0;
        end else begin
            if (w_start) begin
                r_m      <= cfg_m;
                r_k      <= cfg_k;
                r_n      <= cfg_n;
                r_a_base <= cfg_a_base;
                r_w_base <= cfg_w_base;
                r_o_base <= cfg_o_base;
                r_relu   <= cfg_relu;
            end
            if (w_load_addr) begin
                r_a_addr <= ADDR_WIDTH'(PW'(w_sel_a) + PW'(w_kt_nxt) * PW'(w_sel_m));
                r_w_addr <= ADDR_WIDTH'(PW'(w_sel_w) +
                            (PW'(w_nt_nxt) * PW'(w_kt_total) + PW'(w_kt_nxt)) * PW'(ARRAY_N));
                r_o_addr <= ADDR_WIDTH'(PW'(w_sel_o) + PW'(w_nt_nxt) * PW'(w_sel_m));
                r_rows   <= (w_k_rem >= PW'(ARRAY_N)) ? RW'(ARRAY_N) : RW'(w_k_rem);
                r_cols   <= (w_n_rem >= PW'(ARRAY_M)) ? CW'(ARRAY_M) : CW'(w_n_rem);
            end
        end
    end

    // Phase sequencing; r_cnt counts down the cycles remaining in the current phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ctl   <= ctl_for(S_IDLE, 1'b0);
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else if (!w_idle && abort) begin
            r_state <= S_IDLE;
            r_ctl   <= ctl_for(S_IDLE, 1'b0);
        end else begin
            r_cnt <= r_cnt - DIM_WIDTH'(1);
            case (r_state)
                S_IDLE: begin
                    r_cnt <= r_cnt;
                    if (w_start) begin
                        if (w_dims_zero) begin
                            r_state <= S_DONE;
                            r_ctl   <= ctl_for(S_DONE, 1'b0);
                            r_err   <= 1'b1;
                        end else begin
                            r_state <= S_LOAD_W;
                            r_ctl   <= ctl_for(S_LOAD_W, 1'b0);
                            r_cnt   <= DIM_WIDTH'(ARRAY_N - 1);
                            r_err   <= 1'b0;
                        end
                    end
                end
                S_LOAD_W: if (w_cnt_zero) begin
                    r_state <= S_COMPUTE;
                    r_ctl   <= ctl_for(S_COMPUTE, w_kt == '0);
                    r_cnt   <= r_m - DIM_WIDTH'(1);
                end
                S_COMPUTE: if (w_cnt_zero) begin
                    r_state <= S_DRAIN;
                    r_ctl   <= ctl_for(S_DRAIN, 1'b0);
                    r_cnt   <= DIM_WIDTH'(ARRAY_N + ARRAY_M - 2);
                end
                S_DRAIN: if (w_cnt_zero) begin
                    if (w_k_last) begin
                        r_state <= S_WRITE;
                        r_ctl   <= ctl_for(S_WRITE, 1'b0);
                        r_cnt   <= r_m - DIM_WIDTH'(1);
                    end else begin
                        r_state <= S_LOAD_W;
                        r_ctl   <= ctl_for(S_LOAD_W, 1'b0);
                        r_cnt   <= DIM_WIDTH'(ARRAY_N - 1);
                    end
                end
                S_WRITE: if (w_cnt_zero) begin
                    if (w_n_last) begin
                        r_state <= S_DONE;
                        r_ctl   <= ctl_for(S_DONE, 1'b0);
                    end else begin
                        r_state <= S_LOAD_W;
                        r_ctl   <= ctl_for(S_LOAD_W, 1'b0);
                        r_cnt   <= DIM_WIDTH'(ARRAY_N - 1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ctl   <= ctl_for(S_IDLE, 1'b0);
                end
            endcase
        end
    end

    assign a_buf_on         = r_ctl.a_buf_on;
    assign w_buf_on         = r_ctl.w_buf_on;
    assign mode             = r_ctl.mode;
    assign o_ag_o_on        = r_ctl.o_on;
    assign operation_signal = r_ctl.op;
    assign busy             = r_ctl.busy;
    assign done             = r_ctl.done;
    assign err              = r_err;
    assign relu_en          = r_relu;
    assign a_base_addr      = r_a_addr;
    assign w_base_addr      = r_w_addr;
    assign o_base_addr      = r_o_addr;
    assign a_num_rows       = r_rows;
    assign w_num_cols       = r_cols;

endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// Scoreboard bench for gemm_tile_sequencer: stimulus pushes the expected control
// transitions of each job; the monitor pops one entry whenever the control outputs change.
module tb_gemm_tile_sequencer;

    localparam int AN = 16;
    localparam int AM = 16;

    logic        clk = 1'b0;
    logic        reset, start, abort, cfg_relu;
    logic [15:0] cfg_m, cfg_k, cfg_n;
    logic [9:0]  cfg_a_base, cfg_w_base, cfg_o_base;
    logic        a_buf_on, w_buf_on, mode, o_ag_o_on, relu_en, busy, done, err;
    logic [9:0]  a_base_addr, w_base_addr, o_base_addr;
    logic [4:0]  a_num_rows, w_num_cols;
    logic [2:0]  operation_signal;

    gemm_tile_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .cfg_m(cfg_m), .cfg_k(cfg_k), .cfg_n(cfg_n),
        .cfg_a_base(cfg_a_base), .cfg_w_base(cfg_w_base), .cfg_o_base(cfg_o_base),
        .cfg_relu(cfg_relu),
        .a_buf_on(a_buf_on), .a_base_addr(a_base_addr), .a_num_rows(a_num_rows),
        .w_buf_on(w_buf_on), .mode(mode), .w_base_addr(w_base_addr), .w_num_cols(w_num_cols),
        .operation_signal(operation_signal), .o_ag_o_on(o_ag_o_on), .o_base_addr(o_base_addr),
        .relu_en(relu_en), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int       cyc;
        logic [2:0] op;
        logic     a_on, w_on, md, o_on, bsy, dn, er, ck;
        int       a, w, o, rows, cols;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   t0     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push_ev(input int c, input int op, input bit a_on, input bit w_on,
                           input bit md, input bit o_on, input bit bsy, input bit dn,
                           input bit er, input bit ck, input int a, input int w,
                           input int o, input int rows, input int cols);
        exp_t e;
        e.cyc = c; e.op = 3'(op); e.a_on = a_on; e.w_on = w_on; e.md = md; e.o_on = o_on;
        e.bsy = bsy; e.dn = dn; e.er = er; e.ck = ck;
        e.a = a; e.w = w; e.o = o; e.rows = rows; e.cols = cols;
        q.push_back(e);
    endtask

    // Expected phase sequence of a whole job started in cycle s.
    task automatic expect_job(input int s, input int m, input int k, input int n,
                              input int ab, input int wb, input int ob);
        int kt_tot, nt_tot, c, rows, cols, a, w, o;
        if (m == 0 || k == 0 || n == 0) begin
            push_ev(s + 1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
            push_ev(s + 2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
            return;
        end
        kt_tot = (k + AN - 1) / AN;
        nt_tot = (n + AM - 1) / AM;
        c = s + 1;
        for (int nt = 0; nt < nt_tot; nt++) begin
            for (int kt = 0; kt < kt_tot; kt++) begin
                rows = (k - kt * AN > AN) ? AN : k - kt * AN;
                cols = (n - nt * AM > AM) ? AM : n - nt * AM;
                a = (ab + kt * m) % 1024;
                w = (wb + (nt * kt_tot + kt) * AN) % 1024;
                o = (ob + nt * m) % 1024;
                push_ev(c, 1, 0, 1, 1, 0, 1, 0, 0, 1, a, w, o, rows, cols);
                c += AN;
                push_ev(c, (kt == 0) ? 2 : 3, 1, 0, 0, 0, 1, 0, 0, 1, a, w, o, rows, cols);
                c += m;
                push_ev(c, 4, 0, 0, 0, 0, 1, 0, 0, 1, a, w, o, rows, cols);
                c += AN + AM - 1;
            end
            push_ev(c, 0, 0, 0, 0, 1, 1, 0, 0, 1, a, w, o, rows, cols);
            c += m;
        end
        push_ev(c, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        push_ev(c + 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: every change of the control outputs must match the next expected entry.
    logic [8:0] mon_prev = '0;
    logic [8:0] mon_cur, mon_exp;
    exp_t       mon_e;
    logic       mon_bad;
    always @(negedge clk) begin
        mon_cur = {operation_signal, a_buf_on, w_buf_on, mode, o_ag_o_on, busy, done};
        if (mon_cur != mon_prev) begin
            mon_prev = mon_cur;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event cyc=%0d got ctl=%b err=%b", cyc, mon_cur, err);
            end else begin
                mon_e   = q.pop_front();
                mon_exp = {mon_e.op, mon_e.a_on, mon_e.w_on, mon_e.md, mon_e.o_on, mon_e.bsy, mon_e.dn};
                mon_bad = (cyc != mon_e.cyc) || (mon_cur != mon_exp) || (err != mon_e.er);
                if (mon_e.ck)
                    mon_bad = mon_bad || (a_base_addr != 10'(mon_e.a)) || (w_base_addr != 10'(mon_e.w)) ||
                              (o_base_addr != 10'(mon_e.o)) || (a_num_rows != 5'(mon_e.rows)) ||
                              (w_num_cols != 5'(mon_e.cols));
                if (mon_bad) begin
                    errors++;
                    $display("FAIL event cyc=%0d ctl=%b err=%b a=%0d w=%0d o=%0d rows=%0d cols=%0d; required cyc=%0d ctl=%b err=%b a=%0d w=%0d o=%0d rows=%0d cols=%0d (addr checked=%0b)",
                             cyc, mon_cur, err, a_base_addr, w_base_addr, o_base_addr, a_num_rows, w_num_cols,
                             mon_e.cyc, mon_exp, mon_e.er, mon_e.a, mon_e.w, mon_e.o, mon_e.rows, mon_e.cols, mon_e.ck);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic wait_empty(input int limit);
        int n = 0;
        while (q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            chk("scoreboard_timeout_pending", q.size(), 0);
            q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic launch(input int m, input int k, input int n, input int ab, input int wb,
                          input int ob, input bit relu, input bit model);
        @(negedge clk);
        cfg_m = 16'(m); cfg_k = 16'(k); cfg_n = 16'(n);
        cfg_a_base = 10'(ab); cfg_w_base = 10'(wb); cfg_o_base = 10'(ob);
        cfg_relu = relu;
        start = 1'b1;
        t0 = cyc;
        if (model) expect_job(t0, m, k, n, ab, wb, ob);
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; cfg_relu = 1'b0;
        cfg_m = '0; cfg_k = '0; cfg_n = '0;
        cfg_a_base = '0; cfg_w_base = '0; cfg_o_base = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_ctl", int'({busy, done, err, a_buf_on, w_buf_on, mode, o_ag_o_on, relu_en, operation_signal}), 0);
        chk("reset_addr", int'({a_base_addr, w_base_addr, o_base_addr, a_num_rows, w_num_cols}), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single tile; a start while busy must be ignored.
        launch(4, 16, 16, 0, 0, 0, 1'b0, 1'b1);
        wait_until(t0 + 30);
        cfg_m = 16'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_until(t0 + 56);
        #1 chk("t1_done_at_56", int'({done, busy}), 3);
        wait_empty(200);

        // Partial edge tiles in both K and N.
        launch(2, 20, 20, 100, 200, 300, 1'b1, 1'b1);
        #1 chk("t2_relu_en", int'(relu_en), 1);
        wait_until(t0 + 201);
        #1 chk("t2_done_at_201", int'(done), 1);
        wait_empty(400);

        // Zero dimension.
        launch(3, 0, 16, 1, 2, 3, 1'b0, 1'b1);
        wait_empty(50);
        chk("t3_err_held", int'(err), 1);

        // abort with start in IDLE: nothing starts, err untouched.
        @(negedge clk);
        cfg_m = 16'd4; cfg_k = 16'd16; cfg_n = 16'd16;
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        #1 chk("t4_abort_start_idle", int'({busy, err}), 1);
        repeat (3) @(negedge clk);

        // Abort during COMPUTE, then a normal job.
        launch(4, 16, 16, 0, 0, 0, 1'b0, 1'b0);
        push_ev(t0 + 1, 1, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        push_ev(t0 + 17, 2, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        push_ev(t0 + 19, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        wait_until(t0 + 18);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1 chk("t5_abort_idle_busy", int'({busy, done}), 0);
        wait_empty(50);
        launch(4, 16, 16, 10, 20, 30, 1'b0, 1'b1);
        wait_empty(200);

        // Asynchronous reset in the middle of DRAIN.
        launch(4, 16, 16, 5, 6, 7, 1'b1, 1'b0);
        push_ev(t0 + 1, 1, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        push_ev(t0 + 17, 2, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        push_ev(t0 + 21, 4, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        push_ev(t0 + 25, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        wait_until(t0 + 24);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("t6_async_reset_ctl", int'({busy, done, a_buf_on, w_buf_on, mode, o_ag_o_on, relu_en, operation_signal}), 0);
        chk("t6_async_reset_waddr", int'(w_base_addr), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("t6_idle_after_release", int'({busy, operation_signal}), 0);
        wait_empty(50);

        // W address wraps modulo 2^ADDR_WIDTH on the second K-tile.
        launch(3, 32, 16, 0, 1020, 0, 1'b0, 1'b1);
        wait_until(t0 + 51);
        #1 chk("t7_w_addr_wrap", int'(w_base_addr), 12);
        wait_empty(200);

        chk("scoreboard_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
